hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates stall, flush and bubble controls around the execute stage for three cases: load-use hazards, control-flow redirects, and multi-cycle execute operations.
- Sits beside stage_execute and is driven by decode/execute sideband signals.
- Owns the hazard FSM, bubble/redirect counters and a stall-cycle performance counter.

Parameters:
- LOAD_BUBBLES, 2, bubble cycles after a load. Load data is forwardable only from writeback; allowed range 1..3.
- IMEM_LATENCY, 1, extra cycles flush_id is held after a redirect to cover in-flight fetches; allowed range 0..3.
- CNT_W, 32, width of the stall_cycles performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  decode-stage source register 1
- id_rs2  in  5  decode-stage source register 2
- id_uses_rs1  in  1  decode instruction reads rs1
- id_uses_rs2  in  1  decode instruction reads rs2
- ex_rd  in  5  execute-stage destination register
- ex_regfile_wr_enable  in  1  execute instruction writes regfile
- ex_result_src  in  2  execute result select; 2'b01 = load
- ex_pc_src  in  1  execute-stage jump/branch taken
- ex_mc_start  in  1  execute holds a multi-cycle op (mul/div), first cycle
- ex_mc_done  in  1  multi-cycle op result valid this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX and execute output registers
- flush_id  out  1  clear IF/ID register to NOP
- flush_ex  out  1  insert bubble into ID/EX (NOP, all write enables 0)
- hz_state  out  2  current FSM state (debug)
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Reset (rst_n low, async): state RUN, bubble and redirect counters 0, stall_cycles 0. Every control output reads 0 while rst_n is low.
- FSM state encoding: RUN=0, LOAD_STALL=1, MC_BUSY=2, REDIRECT=3.
- Outputs are combinational from state plus inputs; state and counters update on posedge clk.
- Load-use detect (lu):
  - Conditions: ex_result_src==2'b01, ex_regfile_wr_enable, ex_rd!=0, and ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - rd x0 never creates a hazard.
- RUN, priority ex_pc_src > ex_mc_start > lu:
  - ex_pc_src: flush_id=1 and flush_ex=1 this cycle. If IMEM_LATENCY>0, go REDIRECT with redirect counter=IMEM_LATENCY, else stay RUN.
  - ex_mc_start & !ex_mc_done: stall_if=stall_id=stall_ex=1; go MC_BUSY.
  - ex_mc_start & ex_mc_done (single-cycle completion): no stall; stay RUN.
  - lu: stall_if=stall_id=1, flush_ex=1 (bubble 1). If LOAD_BUBBLES>1, go LOAD_STALL with bubble counter=LOAD_BUBBLES-1.
  - Otherwise all controls 0.
- LOAD_STALL:
  - stall_if=stall_id=1, flush_ex=1.
  - Decrement the bubble counter; go RUN when it reaches 1 in this cycle.
  - Total bubbles inserted = LOAD_BUBBLES exactly.
  - ex_pc_src and ex_mc_start are ignored here; EX holds a bubble.
- MC_BUSY:
  - stall_if=stall_id=stall_ex=1 while ex_mc_done=0.
  - On the ex_mc_done cycle, all stalls are 0 and the state returns to RUN; the result latches on that edge.
  - lu is not evaluated in MC_BUSY. The decode instruction is re-checked in RUN on the following cycle.
- REDIRECT:
  - flush_id=1 only; flush_ex=0, stalls 0.
  - Decrement the redirect counter; go RUN when it reaches 1.
  - A new ex_pc_src here (cannot legally occur) restarts the counter at IMEM_LATENCY with flush_ex=1.
- stall_cycles: increments by 1 each cycle stall_if=1 and saturates at all-ones.
- Reset mid-stall: controls drop to 0 immediately (async), and the state returns to RUN.

Decomposition:
- Package core_pkg holds:
  - hz_state_t enum (RUN, LOAD_STALL, MC_BUSY, REDIRECT)
  - RESULT_SRC_LOAD = 2'b01 constant
  - REG_ZERO = 5'd0 constant
- Single module. The hazard compare is one combinational block inside it; no sub-module is warranted.

Test Plan:
- Load-use: ex_result_src=01, ex_rd=5, wr_en=1, id_rs1=5, id_uses_rs1=1.
  - Expected: stall_if=stall_id=flush_ex=1 for exactly 2 cycles, hz_state 0→1→0, stall_cycles=2.
- x0 load: ex_rd=0, id_rs1=0 with a load in EX.
  - Expected: no stall or flush; stall_cycles=0.
- Taken jump: ex_pc_src=1 for one cycle in RUN.
  - Expected: flush_id=flush_ex=1 that cycle, then flush_id=1 only for 1 cycle; stall_if never set.
- Multi-cycle op: ex_mc_start=1, ex_mc_done asserted 4 cycles later.
  - Expected: stall_if/id/ex high for 4 cycles, low on the done cycle; stall_cycles=4.
- Priority: ex_pc_src=1 and load-use condition in the same RUN cycle.
  - Expected: flush only; no stall; next state REDIRECT.
- Async reset: assert rst_n=0 in LOAD_STALL mid-clock.
  - Expected: all controls 0 immediately, hz_state=0, stall_cycles=0; after release, idle RUN behaviour.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the 5-stage core's pipeline control.
//   hz_state_t      : hazard controller FSM states (encoding is visible on the
//                     hz_state debug port, so the values are fixed)
//   RESULT_SRC_LOAD : ex_result_src value that selects load data
//   REG_ZERO        : architectural x0, which never carries a dependency
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MC_BUSY    = 2'd2,
    REDIRECT   = 2'd3
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller that sits beside the execute stage. It
// produces stall / flush / bubble controls for load-use hazards, taken
// control-flow redirects and multi-cycle execute operations, and keeps a
// saturating count of stalled fetch cycles.
//
// Parameters
//   LOAD_BUBBLES : bubbles after a load (1..3); load data forwards from WB only
//   IMEM_LATENCY : extra cycles flush_id stays high after a redirect (0..3)
//   CNT_W        : width of the stall_cycles performance counter
//
// Ports
//   clk, rst_n                 : core clock, asynchronous active-low reset
//   id_rs1/id_rs2              : decode-stage source registers
//   id_uses_rs1/id_uses_rs2    : decode instruction actually reads rs1/rs2
//   ex_rd                      : execute-stage destination register
//   ex_regfile_wr_enable       : execute instruction writes the regfile
//   ex_result_src              : execute result select (2'b01 = load)
//   ex_pc_src                  : execute-stage branch/jump taken
//   ex_mc_start / ex_mc_done   : multi-cycle op first cycle / result valid
//   stall_if/stall_id/stall_ex : hold PC / IF-ID / ID-EX and EX outputs
//   flush_id / flush_ex        : clear IF-ID / insert bubble into ID-EX
//   hz_state                   : current FSM state (debug)
//   stall_cycles               : saturating count of cycles with stall_if=1
// ---------------------------------------------------------------------------
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_BUBBLES = 2,
  parameter int IMEM_LATENCY = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regfile_wr_enable,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_pc_src,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cycles
);

  // Reload values for the two down-counters. The first load bubble is issued
  // from RUN, so LOAD_STALL only has to cover the remaining ones.
  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0] RDR_INIT = 2'(IMEM_LATENCY);

  hz_state_t        state_q, state_d;
  logic [1:0]       bub_cnt_q, bub_cnt_d;
  logic [1:0]       rdr_cnt_q, rdr_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q;

  logic load_use;
  logic sif_c, sid_c, sex_c, fid_c, fex_c;

  // Load-use hazard: a load in EX whose destination is read by the decode
  // instruction. x0 is hard-wired to zero, so it never creates a dependency.
  assign load_use = (ex_result_src == RESULT_SRC_LOAD) && ex_regfile_wr_enable &&
                    (ex_rd != REG_ZERO) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    rdr_cnt_d = rdr_cnt_q;
    sif_c     = 1'b0;
    sid_c     = 1'b0;
    sex_c     = 1'b0;
    fid_c     = 1'b0;
    fex_c     = 1'b0;

    unique case (state_q)
      RUN: begin
        // Priority: redirect > multi-cycle op > load-use.
        if (ex_pc_src) begin
          fid_c = 1'b1;
          fex_c = 1'b1;
          if (IMEM_LATENCY > 0) begin
            state_d   = REDIRECT;
            rdr_cnt_d = RDR_INIT;
          end
        end else if (ex_mc_start) begin
          // A multi-cycle op that finishes in its first cycle needs no stall.
          if (!ex_mc_done) begin
            sif_c   = 1'b1;
            sid_c   = 1'b1;
            sex_c   = 1'b1;
            state_d = MC_BUSY;
          end
        end else if (load_use) begin
          sif_c = 1'b1;
          sid_c = 1'b1;
          fex_c = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d   = LOAD_STALL;
            bub_cnt_d = BUB_INIT;
          end
        end
      end

      LOAD_STALL: begin
        // EX holds a bubble, so redirects and multi-cycle starts cannot
        // originate here; those inputs are deliberately ignored.
        sif_c = 1'b1;
        sid_c = 1'b1;
        fex_c = 1'b1;
        if (bub_cnt_q <= 2'd1) begin
          state_d   = RUN;
          bub_cnt_d = 2'd0;
        end else begin
          bub_cnt_d = bub_cnt_q - 2'd1;
        end
      end

      MC_BUSY: begin
        // The decode instruction is re-checked for load-use back in RUN.
        if (ex_mc_done) begin
          state_d = RUN;
        end else begin
          sif_c = 1'b1;
          sid_c = 1'b1;
          sex_c = 1'b1;
        end
      end

      REDIRECT: begin
        fid_c = 1'b1;
        if (ex_pc_src) begin
          // Not expected from a legal pipeline; treated as a fresh redirect.
          fex_c     = 1'b1;
          rdr_cnt_d = RDR_INIT;
        end else if (rdr_cnt_q <= 2'd1) begin
          state_d   = RUN;
          rdr_cnt_d = 2'd0;
        end else begin
          rdr_cnt_d = rdr_cnt_q - 2'd1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // Controls are combinational from inputs too, so gating with rst_n is what
  // keeps them at zero for the whole time reset is asserted.
  assign stall_if = rst_n & sif_c;
  assign stall_id = rst_n & sid_c;
  assign stall_ex = rst_n & sex_c;
  assign flush_id = rst_n & fid_c;
  assign flush_ex = rst_n & fex_c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      bub_cnt_q <= 2'd0;
      rdr_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
      rdr_cnt_q <= rdr_cnt_d;
    end
  end

  // Saturating stall counter: holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall_if && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign hz_state     = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: a directed vector table, hand-written
// multi-cycle sequences (long multi-cycle op, counter saturation, async reset
// in the middle of a load stall) and a randomized run against a behavioural
// model. A small counter width makes saturation reachable.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int LB    = 2;
  localparam int IML   = 1;
  localparam int CW    = 4;
  localparam int SCMAX = (1 << CW) - 1;

  // Expected-output packing: {stall_if, stall_id, stall_ex, flush_id,
  // flush_ex, hz_state[1:0], stall_cycles[3:0]}.
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LOAD = 5'b11001;
  localparam logic [4:0] C_MC   = 5'b11100;
  localparam logic [4:0] C_JMP  = 5'b00011;
  localparam logic [4:0] C_RDR  = 5'b00010;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic [1:0] src;
    logic       pc;
    logic       mcs;
    logic       mcd;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [10:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_regfile_wr_enable;
  logic [1:0]    ex_result_src;
  logic          ex_pc_src, ex_mc_start, ex_mc_done;
  logic          stall_if, stall_id, stall_ex, flush_id, flush_ex;
  logic [1:0]    hz_state;
  logic [CW-1:0] stall_cycles;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model state: bubbles still owed, redirect flush cycles still
  // owed, whether a multi-cycle op is outstanding, and the stall count.
  int load_left;
  int redir_left;
  bit mc_busy;
  int m_sc;

  hazard_ctrl #(
    .LOAD_BUBBLES(LB),
    .IMEM_LATENCY(IML),
    .CNT_W       (CW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .id_rs1              (id_rs1),
    .id_rs2              (id_rs2),
    .id_uses_rs1         (id_uses_rs1),
    .id_uses_rs2         (id_uses_rs2),
    .ex_rd               (ex_rd),
    .ex_regfile_wr_enable(ex_regfile_wr_enable),
    .ex_result_src       (ex_result_src),
    .ex_pc_src           (ex_pc_src),
    .ex_mc_start         (ex_mc_start),
    .ex_mc_done          (ex_mc_done),
    .stall_if            (stall_if),
    .stall_id            (stall_id),
    .stall_ex            (stall_ex),
    .flush_id            (flush_id),
    .flush_ex            (flush_ex),
    .hz_state            (hz_state),
    .stall_cycles        (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(int rs1, int rs2, int u1, int u2, int rd,
                                int wr, int src, int pc, int mcs, int mcd);
    in_t i;
    i.rs1 = 5'(rs1);  i.rs2 = 5'(rs2);
    i.u1  = 1'(u1);   i.u2  = 1'(u2);
    i.rd  = 5'(rd);   i.wr  = 1'(wr);
    i.src = 2'(src);  i.pc  = 1'(pc);
    i.mcs = 1'(mcs);  i.mcd = 1'(mcd);
    return i;
  endfunction

  function automatic logic [10:0] ex(logic [4:0] ctl, int st, int sc);
    return {ctl, 2'(st), 4'(sc)};
  endfunction

  function automatic logic [10:0] outs();
    return {stall_if, stall_id, stall_ex, flush_id, flush_ex, hz_state, stall_cycles};
  endfunction

  task automatic drive(input in_t i);
    id_rs1               = i.rs1;
    id_rs2               = i.rs2;
    id_uses_rs1          = i.u1;
    id_uses_rs2          = i.u2;
    ex_rd                = i.rd;
    ex_regfile_wr_enable = i.wr;
    ex_result_src        = i.src;
    ex_pc_src            = i.pc;
    ex_mc_start          = i.mcs;
    ex_mc_done           = i.mcd;
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got ctl=%b st=%0d sc=%0d, expected ctl=%b st=%0d sc=%0d",
               name, act[10:6], act[5:4], act[3:0], exp[10:6], exp[5:4], exp[3:0]);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare settled outputs
  // before the next rising edge.
  task automatic step(input in_t i, input logic [10:0] exp, input string name);
    @(negedge clk);
    drive(i);
    #1;
    check(name, outs(), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    load_left  = 0;
    redir_left = 0;
    mc_busy    = 1'b0;
    m_sc       = 0;
  endtask

  // Model evaluation for one cycle: returns the expected outputs for the
  // current inputs and advances the model across the coming clock edge.
  task automatic model_step(input in_t i, output logic [10:0] exp);
    logic [4:0] ctl;
    int         st;
    bit         hit;
    hit = (i.src == 2'b01) && i.wr && (i.rd != 0) &&
          ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    st  = (load_left > 0) ? 1 : mc_busy ? 2 : (redir_left > 0) ? 3 : 0;
    ctl = C_NONE;
    if (load_left > 0) begin
      ctl = C_LOAD;
      load_left--;
    end else if (mc_busy) begin
      if (i.mcd) mc_busy = 1'b0;
      else       ctl = C_MC;
    end else if (redir_left > 0) begin
      if (i.pc) begin
        ctl        = C_JMP;
        redir_left = IML;
      end else begin
        ctl = C_RDR;
        redir_left--;
      end
    end else if (i.pc) begin
      ctl        = C_JMP;
      redir_left = IML;
    end else if (i.mcs) begin
      if (!i.mcd) begin
        ctl     = C_MC;
        mc_busy = 1'b1;
      end
    end else if (hit) begin
      ctl       = C_LOAD;
      load_left = LB - 1;
    end
    exp = ex(ctl, st, m_sc);
    if (ctl[4] && m_sc < SCMAX) m_sc++;
  endtask

  vec_t tbl[28];

  initial begin
    in_t         idle, lu5, rin;
    logic [10:0] e;

    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5  = mk_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);

    // Directed table, applied back to back from reset.
    tbl[0]  = '{lu5,                                     ex(C_LOAD, 0, 0)};
    tbl[1]  = '{idle,                                    ex(C_LOAD, 1, 1)};
    tbl[2]  = '{idle,                                    ex(C_NONE, 0, 2)};
    tbl[3]  = '{mk_in(0, 0, 1, 1, 0, 1, 1, 0, 0, 0),     ex(C_NONE, 0, 2)};
    tbl[4]  = '{mk_in(3, 7, 1, 1, 7, 1, 1, 0, 0, 0),     ex(C_LOAD, 0, 2)};
    tbl[5]  = '{idle,                                    ex(C_LOAD, 1, 3)};
    tbl[6]  = '{idle,                                    ex(C_NONE, 0, 4)};
    tbl[7]  = '{mk_in(9, 9, 0, 0, 9, 1, 1, 0, 0, 0),     ex(C_NONE, 0, 4)};
    tbl[8]  = '{mk_in(9, 0, 1, 0, 9, 1, 0, 0, 0, 0),     ex(C_NONE, 0, 4)};
    tbl[9]  = '{mk_in(9, 0, 1, 0, 9, 0, 1, 0, 0, 0),     ex(C_NONE, 0, 4)};
    tbl[10] = '{mk_in(9, 0, 1, 0, 9, 1, 3, 0, 0, 0),     ex(C_NONE, 0, 4)};
    tbl[11] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),     ex(C_JMP,  0, 4)};
    tbl[12] = '{idle,                                    ex(C_RDR,  3, 4)};
    tbl[13] = '{idle,                                    ex(C_NONE, 0, 4)};
    tbl[14] = '{mk_in(5, 0, 1, 0, 5, 1, 1, 1, 0, 0),     ex(C_JMP,  0, 4)};
    tbl[15] = '{idle,                                    ex(C_RDR,  3, 4)};
    tbl[16] = '{idle,                                    ex(C_NONE, 0, 4)};
    tbl[17] = '{lu5,                                     ex(C_LOAD, 0, 4)};
    tbl[18] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),     ex(C_LOAD, 1, 5)};
    tbl[19] = '{idle,                                    ex(C_NONE, 0, 6)};
    tbl[20] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1),     ex(C_NONE, 0, 6)};
    tbl[21] = '{mk_in(5, 0, 1, 0, 5, 1, 1, 0, 1, 0),     ex(C_MC,   0, 6)};
    tbl[22] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),     ex(C_NONE, 2, 7)};
    tbl[23] = '{idle,                                    ex(C_NONE, 0, 7)};
    tbl[24] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),     ex(C_JMP,  0, 7)};
    tbl[25] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),     ex(C_JMP,  3, 7)};
    tbl[26] = '{idle,                                    ex(C_RDR,  3, 7)};
    tbl[27] = '{idle,                                    ex(C_NONE, 0, 7)};

    // Reset state, with hazard-causing inputs present to show gating.
    rst_n = 1'b0;
    drive(mk_in(5, 0, 1, 0, 5, 1, 1, 1, 0, 0));
    #2;
    check("reset_state", outs(), ex(C_NONE, 0, 0));
    do_reset();

    for (int k = 0; k < 28; k++) begin
      step(tbl[k].in, tbl[k].exp, $sformatf("tbl[%0d]", k));
    end

    // Multi-cycle op with done four cycles after start.
    do_reset();
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_MC, 0, 0), "mc_start");
    for (int k = 1; k < 4; k++) begin
      step(idle, ex(C_MC, 2, k), $sformatf("mc_busy%0d", k));
    end
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(C_NONE, 2, 4), "mc_done");
    step(idle, ex(C_NONE, 0, 4), "mc_after");

    // Stall counter saturation at all-ones.
    do_reset();
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_MC, 0, 0), "sat_start");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(idle);
    end
    #1;
    check("sat_hold", outs(), ex(C_MC, 2, SCMAX));
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(C_NONE, 2, SCMAX), "sat_done");

    // Async reset asserted mid-cycle while in LOAD_STALL.
    do_reset();
    step(lu5, ex(C_LOAD, 0, 0), "ar_enter");
    @(posedge clk);
    #2;
    check("ar_in_stall", outs(), ex(C_LOAD, 1, 1));
    rst_n = 1'b0;
    #1;
    check("ar_asserted", outs(), ex(C_NONE, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle);
    #1;
    check("ar_released", outs(), ex(C_NONE, 0, 0));
    step(idle, ex(C_NONE, 0, 0), "ar_idle");

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rin = mk_in($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      model_step(rin, e);
      step(rin, e, $sformatf("rand[%0d]", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
